tcc32_apb_timer: RTL and testbench



---
 rtl/tcc32_apb_timer.sv | 207 ++++++++++++++++++++
 tb/tb_tcc32_apb_timer.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcc32_apb_timer.sv
// -----------------------------------------------------------------------------
// tcc32_apb_timer
//
// 32-bit timer/counter with capture and PWM behind a single APB slave port.
// The timer occupies a 4 KB window (offset = (paddr - BASE_ADDR)[11:0]).
//
// It counts either prescaled pclk ticks or rising edges of ext_clk. When
// CS=0, it can capture TIMER on ext_clk rising edges. It drives a registered
// PWM output and a registered level interrupt.
//
// Ports:
//   pclk, prst_n   APB clock and asynchronous active-low reset
//   psel, penable  APB handshake (zero wait states, pready tied high)
//   pwrite, paddr  APB direction and address
//   pwdata         APB write data
//   prdata         APB read data, combinational, 0 when psel is low
//   pready         always 1
//   pslverr        always 0
//   ext_clk        external clock / capture input, asynchronous to pclk
//   irq            level interrupt, |(RIS & IM) registered
//   gpio_pwm       registered PWM output
// -----------------------------------------------------------------------------
module tcc32_apb_timer #(
  parameter int                    APB_ADDR_W = 32,
  parameter int                    APB_DATA_W = 32,
  parameter logic [APB_ADDR_W-1:0] BASE_ADDR  = '0
) (
  input  logic                  pclk,
  input  logic                  prst_n,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [APB_ADDR_W-1:0] paddr,
  input  logic [APB_DATA_W-1:0] pwdata,
  output logic [APB_DATA_W-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr,
  input  logic                  ext_clk,
  output logic                  irq,
  output logic                  gpio_pwm
);

  localparam logic [11:0] OFF_TIMER    = 12'h000;
  localparam logic [11:0] OFF_PERIOD   = 12'h004;
  localparam logic [11:0] OFF_PWMCMP   = 12'h008;
  localparam logic [11:0] OFF_PRESCALE = 12'h00C;
  localparam logic [11:0] OFF_CTRL     = 12'h010;
  localparam logic [11:0] OFF_CAPTURE  = 12'h014;
  localparam logic [11:0] OFF_IM       = 12'hF00;
  localparam logic [11:0] OFF_MIS      = 12'hF04;
  localparam logic [11:0] OFF_RIS      = 12'hF08;
  localparam logic [11:0] OFF_IC       = 12'hF0C;

  // Register state
  logic [31:0] timer;
  logic [31:0] period;
  logic [31:0] pwmcmp;
  logic [15:0] prescale;
  logic [15:0] presc_cnt;
  logic [31:0] capture;
  logic        te, pe, cs, os, ce;
  logic [2:0]  im;
  logic [2:0]  ris;

  // ext_clk synchronizer and edge detector
  logic [1:0]  sync_ff;
  logic        ext_prev;
  logic        ext_rise;

  // Decode
  logic [APB_ADDR_W-1:0] rel_addr;
  logic [11:0]           offset;
  logic                  unused_addr;
  logic                  wr;
  logic                  wr_ctrl;
  logic                  ts_req;
  logic                  te_kill;
  logic [2:0]            ic_clr;

  // Tick and next-state helpers
  logic        presc_hit;
  logic        tick;
  logic        wrap;
  logic [31:0] timer_next;
  logic [2:0]  ris_set;

  assign pready  = 1'b1;
  assign pslverr = 1'b0;

  assign rel_addr    = paddr - BASE_ADDR;
  assign offset      = rel_addr[11:0];
  assign unused_addr = &{1'b0, rel_addr[APB_ADDR_W-1:12]};

  assign wr      = psel & penable & pwrite;
  assign wr_ctrl = wr && (offset == OFF_CTRL);
  assign ts_req  = wr_ctrl & pwdata[1];
  // A CTRL write that clears TE swallows any tick landing in the same cycle.
  assign te_kill = wr_ctrl & ~pwdata[0];
  assign ic_clr  = (wr && (offset == OFF_IC)) ? pwdata[2:0] : 3'b000;

  assign ext_rise = sync_ff[1] & ~ext_prev;

  // Tick generation. ">=" lets the prescaler recover at once if PRESCALE is
  // lowered below the running count; otherwise it behaves as an equality.
  always_comb begin
    presc_hit  = (presc_cnt >= prescale);
    tick       = 1'b0;
    if (te && !te_kill && !ts_req) begin
      tick = cs ? ext_rise : presc_hit;
    end
    wrap       = (timer == period);
    timer_next = wrap ? 32'd0 : timer + 32'd1;
    ris_set    = {ce & ~cs & ext_rise,
                  tick & (timer_next == pwmcmp),
                  tick & wrap};
  end

  // Two-flop synchronizer plus one delayed copy for rising-edge detection.
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      sync_ff  <= 2'b00;
      ext_prev <= 1'b0;
    end else begin
      sync_ff  <= {sync_ff[0], ext_clk};
      ext_prev <= sync_ff[1];
    end
  end

  // Counter, prescaler, configuration registers, flags and outputs.
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      timer     <= 32'd0;
      period    <= 32'hFFFF_FFFF;
      pwmcmp    <= 32'd0;
      prescale  <= 16'd0;
      presc_cnt <= 16'd0;
      capture   <= 32'd0;
      te        <= 1'b0;
      pe        <= 1'b0;
      cs        <= 1'b0;
      os        <= 1'b0;
      ce        <= 1'b0;
      im        <= 3'b000;
      ris       <= 3'b000;
      irq       <= 1'b0;
      gpio_pwm  <= 1'b0;
    end else begin
      // Prescaler only runs in pclk mode while enabled; TS restarts it.
      if (ts_req) begin
        presc_cnt <= 16'd0;
      end else if (te && !cs && !te_kill) begin
        presc_cnt <= presc_hit ? 16'd0 : presc_cnt + 16'd1;
      end

      if (ts_req) begin
        timer <= 32'd0;
      end else if (tick) begin
        timer <= timer_next;
      end

      // An explicit CTRL write takes priority over the one-shot auto-stop.
      if (wr_ctrl) begin
        te <= pwdata[0];
        pe <= pwdata[2];
        cs <= pwdata[3];
        os <= pwdata[4];
        ce <= pwdata[5];
      end else if (tick && wrap && os) begin
        te <= 1'b0;
      end

      if (wr && (offset == OFF_PERIOD))   period   <= pwdata[31:0];
      if (wr && (offset == OFF_PWMCMP))   pwmcmp   <= pwdata[31:0];
      if (wr && (offset == OFF_PRESCALE)) prescale <= pwdata[15:0];
      if (wr && (offset == OFF_IM))       im       <= pwdata[2:0];

      if (ris_set[2]) begin
        capture <= timer;
      end

      // Hardware set beats a software clear of the same bit.
      ris      <= (ris & ~ic_clr) | ris_set;
      irq      <= |(ris & im);
      gpio_pwm <= pe & te & (timer < pwmcmp);
    end
  end

  // Combinational read mux; unmapped offsets and IC read as zero.
  always_comb begin
    prdata = '0;
    if (psel) begin
      case (offset)
        OFF_TIMER:    prdata = timer;
        OFF_PERIOD:   prdata = period;
        OFF_PWMCMP:   prdata = pwmcmp;
        OFF_PRESCALE: prdata = {16'd0, prescale};
        OFF_CTRL:     prdata = {26'd0, ce, os, cs, pe, 1'b0, te};
        OFF_CAPTURE:  prdata = capture;
        OFF_IM:       prdata = {29'd0, im};
        OFF_MIS:      prdata = {29'd0, ris & im};
        OFF_RIS:      prdata = {29'd0, ris};
        default:      prdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_tcc32_apb_timer.sv
// -----------------------------------------------------------------------------
// tb_tcc32_apb_timer
//
// Self-checking bench for tcc32_apb_timer. Each scenario task pushes its
// expected values onto a scoreboard queue as the stimulus is driven. It then
// pops and compares them as the DUT produces the corresponding outputs.
// -----------------------------------------------------------------------------
module tb_tcc32_apb_timer;

  localparam logic [11:0] OFF_TIMER    = 12'h000;
  localparam logic [11:0] OFF_PERIOD   = 12'h004;
  localparam logic [11:0] OFF_PWMCMP   = 12'h008;
  localparam logic [11:0] OFF_PRESCALE = 12'h00C;
  localparam logic [11:0] OFF_CTRL     = 12'h010;
  localparam logic [11:0] OFF_CAPTURE  = 12'h014;
  localparam logic [11:0] OFF_IM       = 12'hF00;
  localparam logic [11:0] OFF_MIS      = 12'hF04;
  localparam logic [11:0] OFF_RIS      = 12'hF08;
  localparam logic [11:0] OFF_IC       = 12'hF0C;

  logic        pclk    = 1'b0;
  logic        prst_n  = 1'b0;
  logic        psel    = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite  = 1'b0;
  logic [31:0] paddr   = 32'd0;
  logic [31:0] pwdata  = 32'd0;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        ext_clk = 1'b0;
  logic        irq;
  logic        gpio_pwm;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  logic [31:0] exp_q[$];
  logic        bit_q[$];

  tcc32_apb_timer #(
    .APB_ADDR_W(32),
    .APB_DATA_W(32),
    .BASE_ADDR (32'd0)
  ) dut (
    .pclk    (pclk),
    .prst_n  (prst_n),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr),
    .ext_clk (ext_clk),
    .irq     (irq),
    .gpio_pwm(gpio_pwm)
  );

  always #5 pclk = ~pclk;

  // Free-running cycle counter used to model TIMER in the capture scenario.
  always @(posedge pclk) cyc <= cyc + 1;

  // APB write; returns 1 ns after the committing edge.
  task automatic apb_write(input logic [11:0] addr, input logic [31:0] data);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = {20'd0, addr}; pwdata = data;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  // APB read; samples the access phase away from the clock edge.
  task automatic apb_read(input logic [11:0] addr, output logic [31:0] data,
                          output logic rdy, output logic err);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = {20'd0, addr};
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk);
    data = prdata; rdy = pready; err = pslverr;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] addrs[10];
    logic [31:0] got, exp;
    logic        rdy, err;
    addrs = '{OFF_TIMER, OFF_PERIOD, OFF_PWMCMP, OFF_PRESCALE, OFF_CTRL,
              OFF_CAPTURE, OFF_IM, OFF_MIS, OFF_RIS, OFF_IC};
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back((addrs[i] == OFF_PERIOD) ? 32'hFFFF_FFFF : 32'd0);
    end
    for (int i = 0; i < 10; i++) begin
      apb_read(addrs[i], got, rdy, err);
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) $display("[TB] FAIL reset_reg[%h]: got %h expected %h", addrs[i], got, exp);
      else passed++;
    end
    total++;
    if (irq !== 1'b0) $display("[TB] FAIL reset_irq: got %b expected 0", irq);
    else passed++;
    total++;
    if (gpio_pwm !== 1'b0) $display("[TB] FAIL reset_pwm: got %b expected 0", gpio_pwm);
    else passed++;
  endtask

  task automatic test_period_wrap();
    logic [31:0] seq[7];
    logic [31:0] got, exp;
    logic        rdy, err, expb;
    seq = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd0, 32'd1};
    apb_write(OFF_PRESCALE, 32'd0);
    apb_write(OFF_PERIOD, 32'd4);
    apb_write(OFF_IM, 32'd1);
    apb_write(OFF_CTRL, 32'h1);
    for (int k = 0; k < 7; k++) begin
      exp_q.push_back(seq[k]);
      bit_q.push_back(k == 6);
    end
    // Hold psel on TIMER so the combinational read can be watched every cycle.
    psel = 1'b1; paddr = {20'd0, OFF_TIMER};
    for (int k = 0; k < 7; k++) begin
      @(negedge pclk);
      exp = exp_q.pop_front();
      expb = bit_q.pop_front();
      total++;
      if (prdata !== exp) $display("[TB] FAIL wrap_timer[%0d]: got %0d expected %0d", k, prdata, exp);
      else passed++;
      total++;
      if (irq !== expb) $display("[TB] FAIL wrap_irq[%0d]: got %b expected %b", k, irq, expb);
      else passed++;
    end
    psel = 1'b0;
    apb_write(OFF_CTRL, 32'h0);
    // TO on the wrap; CM too, since the timer steps to PWMCMP=0.
    exp_q.push_back(32'h3);
    apb_read(OFF_RIS, got, rdy, err);
    exp = exp_q.pop_front();
    total++;
    if (got !== exp) $display("[TB] FAIL wrap_ris: got %h expected %h", got, exp);
    else passed++;
    exp_q.push_back(32'h1);
    apb_read(OFF_MIS, got, rdy, err);
    exp = exp_q.pop_front();
    total++;
    if (got !== exp) $display("[TB] FAIL wrap_mis: got %h expected %h", got, exp);
    else passed++;
    apb_write(OFF_IC, 32'h1);
    @(posedge pclk); #1;
    total++;
    if (irq !== 1'b0) $display("[TB] FAIL ic_irq: got %b expected 0", irq);
    else passed++;
    exp_q.push_back(32'h2);
    apb_read(OFF_RIS, got, rdy, err);
    exp = exp_q.pop_front();
    total++;
    if (got !== exp) $display("[TB] FAIL ic_ris: got %h expected %h", got, exp);
    else passed++;
    apb_write(OFF_IC, 32'h7);
  endtask

  task automatic test_one_shot();
    logic [31:0] seq[10];
    logic [31:0] got, exp;
    logic        rdy, err;
    seq = '{32'd0, 32'd0, 32'd1, 32'd1, 32'd2, 32'd2, 32'd0, 32'd0, 32'd0, 32'd0};
    apb_write(OFF_PRESCALE, 32'd1);
    apb_write(OFF_PERIOD, 32'd2);
    apb_write(OFF_CTRL, 32'h2);
    apb_write(OFF_IC, 32'h7);
    apb_write(OFF_CTRL, 32'h11);
    for (int k = 0; k < 10; k++) exp_q.push_back(seq[k]);
    psel = 1'b1; paddr = {20'd0, OFF_TIMER};
    for (int k = 0; k < 10; k++) begin
      @(negedge pclk);
      exp = exp_q.pop_front();
      total++;
      if (prdata !== exp) $display("[TB] FAIL oneshot_timer[%0d]: got %0d expected %0d", k, prdata, exp);
      else passed++;
    end
    psel = 1'b0;
    exp_q.push_back(32'h10);
    apb_read(OFF_CTRL, got, rdy, err);
    exp = exp_q.pop_front();
    total++;
    if (got !== exp) $display("[TB] FAIL oneshot_ctrl: got %h expected %h", got, exp);
    else passed++;
    exp_q.push_back(32'h3);
    apb_read(OFF_RIS, got, rdy, err);
    exp = exp_q.pop_front();
    total++;
    if (got !== exp) $display("[TB] FAIL oneshot_ris: got %h expected %h", got, exp);
    else passed++;
    // After clearing, a stopped one-shot must raise no further flags.
    apb_write(OFF_IC, 32'h7);
    repeat (10) @(posedge pclk);
    exp_q.push_back(32'h0);
    apb_read(OFF_RIS, got, rdy, err);
    exp = exp_q.pop_front();
    total++;
    if (got !== exp) $display("[TB] FAIL oneshot_once: got %h expected %h", got, exp);
    else passed++;
  endtask

  task automatic test_pwm();
    logic [31:0] cmps[3];
    logic [31:0] exp;
    int          highs, len;
    cmps = '{32'd3, 32'd0, 32'd20};
    apb_write(OFF_PRESCALE, 32'd0);
    apb_write(OFF_PERIOD, 32'd9);
    apb_write(OFF_CTRL, 32'h2);
    for (int c = 0; c < 3; c++) begin
      apb_write(OFF_PWMCMP, cmps[c]);
      if (c == 0) apb_write(OFF_CTRL, 32'h5);
      // Two full periods at 3/10 duty, then 0 of 10 and 10 of 10.
      len = (c == 0) ? 20 : 10;
      exp_q.push_back((c == 0) ? 32'd6 : ((c == 1) ? 32'd0 : 32'd10));
      repeat (3) @(posedge pclk);
      highs = 0;
      for (int k = 0; k < len; k++) begin
        @(negedge pclk);
        if (gpio_pwm === 1'b1) highs++;
      end
      exp = exp_q.pop_front();
      total++;
      if (highs !== int'(exp)) $display("[TB] FAIL pwm_cmp%0d: got %0d high expected %0d", cmps[c], highs, exp);
      else passed++;
    end
    apb_write(OFF_CTRL, 32'h0);
  endtask

  task automatic test_ext_count();
    logic [31:0] got, exp;
    logic        rdy, err;
    apb_write(OFF_PERIOD, 32'hFFFF_FFFF);
    apb_write(OFF_CTRL, 32'h2);
    apb_write(OFF_CTRL, 32'h9);
    exp_q.push_back(32'd5);
    for (int p = 0; p < 5; p++) begin
      @(posedge pclk); #3 ext_clk = 1'b1;
      repeat (4) @(posedge pclk);
      #3 ext_clk = 1'b0;
      repeat (3) @(posedge pclk);
    end
    repeat (4) @(posedge pclk);
    apb_read(OFF_TIMER, got, rdy, err);
    exp = exp_q.pop_front();
    total++;
    if (got !== exp) $display("[TB] FAIL ext_count: got %0d expected %0d", got, exp);
    else passed++;
    apb_write(OFF_CTRL, 32'h0);
  endtask

  task automatic test_capture();
    logic [31:0] got, exp;
    logic        rdy, err;
    int          en_cyc, c0;
    apb_write(OFF_CTRL, 32'h2);
    apb_write(OFF_IC, 32'h7);
    // TS together with TE: TIMER is 0 after this edge and counts every cycle.
    apb_write(OFF_CTRL, 32'h23);
    en_cyc = cyc;
    for (int i = 0; i < 3; i++) begin
      repeat (2 + i) @(posedge pclk);
      #1 ext_clk = 1'b1;
      c0 = cyc;
      // Two synchronizer stages, then the edge pulse latches on the third edge.
      exp_q.push_back(32'(c0 + 2 - en_cyc));
      repeat (4) @(posedge pclk);
      #1 ext_clk = 1'b0;
      repeat (4) @(posedge pclk);
      apb_read(OFF_CAPTURE, got, rdy, err);
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) $display("[TB] FAIL capture[%0d]: got %0d expected %0d", i, got, exp);
      else passed++;
      apb_read(OFF_RIS, got, rdy, err);
      total++;
      if (got[2] !== 1'b1) $display("[TB] FAIL capture_cp[%0d]: got %b expected 1", i, got[2]);
      else passed++;
      apb_write(OFF_IC, 32'h4);
    end
    apb_write(OFF_CTRL, 32'h0);
  endtask

  task automatic test_unmapped();
    logic [31:0] got, exp;
    logic        rdy, err;
    apb_write(OFF_PERIOD, 32'h0000_1234);
    apb_write(OFF_PWMCMP, 32'h0000_0055);
    exp_q.push_back(32'd0);
    apb_read(12'h100, got, rdy, err);
    exp = exp_q.pop_front();
    total++;
    if (got !== exp) $display("[TB] FAIL unmapped_read: got %h expected %h", got, exp);
    else passed++;
    total++;
    if (rdy !== 1'b1) $display("[TB] FAIL pready: got %b expected 1", rdy);
    else passed++;
    total++;
    if (err !== 1'b0) $display("[TB] FAIL pslverr: got %b expected 0", err);
    else passed++;
    apb_write(12'h100, 32'hDEAD_BEEF);
    exp_q.push_back(32'h0000_1234);
    exp_q.push_back(32'h0000_0055);
    apb_read(OFF_PERIOD, got, rdy, err);
    exp = exp_q.pop_front();
    total++;
    if (got !== exp) $display("[TB] FAIL unmapped_period: got %h expected %h", got, exp);
    else passed++;
    apb_read(OFF_PWMCMP, got, rdy, err);
    exp = exp_q.pop_front();
    total++;
    if (got !== exp) $display("[TB] FAIL unmapped_pwmcmp: got %h expected %h", got, exp);
    else passed++;
  endtask

  task automatic test_reset_midcount();
    logic [31:0] got, exp;
    logic        rdy, err;
    apb_write(OFF_PRESCALE, 32'd0);
    apb_write(OFF_CTRL, 32'h7);
    repeat (6) @(posedge pclk);
    exp_q.push_back(32'd0);
    psel = 1'b1; paddr = {20'd0, OFF_TIMER};
    @(negedge pclk);
    #2 prst_n = 1'b0;
    #1;
    exp = exp_q.pop_front();
    total++;
    if (prdata !== exp) $display("[TB] FAIL midreset_timer: got %0d expected %0d", prdata, exp);
    else passed++;
    total++;
    if (gpio_pwm !== 1'b0 || irq !== 1'b0)
      $display("[TB] FAIL midreset_outputs: got pwm=%b irq=%b expected 0 0", gpio_pwm, irq);
    else passed++;
    psel = 1'b0;
    repeat (2) @(posedge pclk);
    #2 prst_n = 1'b1;
    exp_q.push_back(32'h0);
    apb_read(OFF_CTRL, got, rdy, err);
    exp = exp_q.pop_front();
    total++;
    if (got !== exp) $display("[TB] FAIL midreset_ctrl: got %h expected %h", got, exp);
    else passed++;
  endtask

  initial begin
    prst_n = 1'b0;
    repeat (3) @(posedge pclk);
    #2 prst_n = 1'b1;
    test_reset();
    test_period_wrap();
    test_one_shot();
    test_pwm();
    test_ext_count();
    test_capture();
    test_unmapped();
    test_reset_midcount();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
